// File: rtl/vga_balayage.sv
// Raster scan generator and registered VGA output stage: pixel counters, a
// once-per-frame pulse, and blanking-gated colour with aligned sync signals.
module vga_balayage #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] rouge_in,
  input  logic [2:0] vert_in,
  input  logic [1:0] bleu_in,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       visible,
  output logic       tick_pixel,
  output logic       fin_image,
  output logic [2:0] vga_rouge,
  output logic [2:0] vga_vert,
  output logic [1:0] vga_bleu,
  output logic       hsync,
  output logic       vsync
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [2:0] DIV_LAST = 3'(CLK_DIV - 1);

  logic [2:0] div;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       lineEnd;
  logic       frameEnd;
  logic       hSyncNext;
  logic       vSyncNext;

  // The counters are the whole scan state; x/y expose them directly.
  assign x = hcount;
  assign y = vcount;

  always_comb begin
    tick_pixel = ~reset & (div == DIV_LAST);
    lineEnd    = (hcount == H_LAST);
    frameEnd   = (vcount == V_LAST);
    visible    = (hcount < H_VIS) && (vcount < V_VIS);
    fin_image  = tick_pixel & lineEnd & frameEnd;
    hSyncNext  = ~((hcount >= HS_START) && (hcount < HS_END));
    vSyncNext  = ~((vcount >= VS_START) && (vcount < VS_END));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div <= 3'd0;
    end else if (tick_pixel) begin
      div <= 3'd0;
    end else begin
      div <= div + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcount <= 10'd0;
      vcount <= 10'd0;
    end else if (tick_pixel) begin
      if (lineEnd) begin
        hcount <= 10'd0;
        vcount <= frameEnd ? 10'd0 : vcount + 10'd1;
      end else begin
        hcount <= hcount + 10'd1;
      end
    end
  end

  // Colour and sync share one register so the connector sees them aligned,
  // one pixel after the counter value that produced them.
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_rouge <= 3'd0;
      vga_vert  <= 3'd0;
      vga_bleu  <= 2'd0;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
    end else if (tick_pixel) begin
      vga_rouge <= visible ? rouge_in : 3'd0;
      vga_vert  <= visible ? vert_in  : 3'd0;
      vga_bleu  <= visible ? bleu_in  : 2'd0;
      hsync     <= hSyncNext;
      vsync     <= vSyncNext;
    end
  end

endmodule
